// File: rtl/i3c_cpuif_arb.sv
// Two-requester round-robin arbiter in front of a CSR cpuif, one transfer outstanding.
// Optional response timeout is enabled by defining I3C_CPUIF_ARB_TIMEOUT_EN.
module i3c_cpuif_arb #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    hclk_i,
  input  logic                    hreset_n_i,
  input  logic [1:0]              m_req_i,
  input  logic [1:0]              m_req_is_wr_i,
  input  logic [2*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [2*DATA_WIDTH-1:0] m_wr_data_i,
  input  logic [2*DATA_WIDTH-1:0] m_wr_biten_i,
  output logic [1:0]              m_ack_o,
  output logic                    m_err_o,
  output logic [DATA_WIDTH-1:0]   m_rd_data_o,
  output logic                    s_cpuif_req,
  output logic                    s_cpuif_req_is_wr,
  output logic [ADDR_WIDTH-1:0]   s_cpuif_addr,
  output logic [DATA_WIDTH-1:0]   s_cpuif_wr_data,
  output logic [DATA_WIDTH-1:0]   s_cpuif_wr_biten,
  input  logic                    s_cpuif_req_stall_wr,
  input  logic                    s_cpuif_req_stall_rd,
  input  logic                    s_cpuif_rd_ack,
  input  logic                    s_cpuif_rd_err,
  input  logic [DATA_WIDTH-1:0]   s_cpuif_rd_data,
  input  logic                    s_cpuif_wr_ack,
  input  logic                    s_cpuif_wr_err,
  output logic                    timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                  state_r, state_next_s;
  logic                    ptr_r, grant_r, is_wr_r, err_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wr_data_r, biten_r, rd_data_r;
  logic                    pick_s, stall_s, issue_s, ack_s, ack_err_s;
  logic                    complete_s, timeout_hit_s;

  // Only the handshake of the latched direction matters; the other is ignored.
  assign stall_s    = is_wr_r ? s_cpuif_req_stall_wr : s_cpuif_req_stall_rd;
  assign ack_s      = is_wr_r ? s_cpuif_wr_ack : s_cpuif_rd_ack;
  assign ack_err_s  = is_wr_r ? s_cpuif_wr_err : s_cpuif_rd_err;
  assign issue_s    = (state_r == ISSUE) && !stall_s;
  assign complete_s = (issue_s || (state_r == WAIT)) && ack_s;

  // Round-robin pick: pointer breaks ties, a lone requester always wins.
  always_comb begin
    pick_s = 1'b0;
    if (m_req_i == 2'b11) begin
      pick_s = ptr_r;
    end else if (m_req_i[1]) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

`ifdef I3C_CPUIF_ARB_TIMEOUT_EN
  logic [15:0] cnt_r;
  logic        tmo_r;

  assign timeout_hit_s = (state_r == WAIT) && !ack_s &&
                         (cnt_r == 16'(TIMEOUT_CYCLES - 1));

  // Wait-cycle counter, zero on every WAIT entry; tmo_r marks a timeout RESP.
  always_ff @(posedge hclk_i or negedge hreset_n_i) begin
    if (!hreset_n_i) begin
      cnt_r <= 16'd0;
      tmo_r <= 1'b0;
    end else begin
      cnt_r <= (state_r == WAIT) ? cnt_r + 16'd1 : 16'd0;
      tmo_r <= timeout_hit_s;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge hclk_i or negedge hreset_n_i) begin
    if (!hreset_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = (m_req_i != 2'b00) ? ISSUE : IDLE;
      ISSUE:   state_next_s = issue_s ? (ack_s ? RESP : WAIT) : ISSUE;
      WAIT:    state_next_s = (ack_s || timeout_hit_s) ? RESP : WAIT;
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Grant/payload capture in IDLE, response capture on ack or timeout.
  always_ff @(posedge hclk_i or negedge hreset_n_i) begin
    if (!hreset_n_i) begin
      ptr_r     <= 1'b0;
      grant_r   <= 1'b0;
      is_wr_r   <= 1'b0;
      addr_r    <= {ADDR_WIDTH{1'b0}};
      wr_data_r <= {DATA_WIDTH{1'b0}};
      biten_r   <= {DATA_WIDTH{1'b0}};
      err_r     <= 1'b0;
      rd_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if ((state_r == IDLE) && (m_req_i != 2'b00)) begin
        grant_r   <= pick_s;
        ptr_r     <= ~pick_s;
        is_wr_r   <= m_req_is_wr_i[pick_s];
        addr_r    <= pick_s ? m_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_addr_i[ADDR_WIDTH-1:0];
        wr_data_r <= pick_s ? m_wr_data_i[2*DATA_WIDTH-1:DATA_WIDTH] : m_wr_data_i[DATA_WIDTH-1:0];
        biten_r   <= pick_s ? m_wr_biten_i[2*DATA_WIDTH-1:DATA_WIDTH] : m_wr_biten_i[DATA_WIDTH-1:0];
      end
      if (complete_s) begin
        err_r     <= ack_err_s;
        rd_data_r <= is_wr_r ? {DATA_WIDTH{1'b0}} : s_cpuif_rd_data;
      end else if (timeout_hit_s) begin
        err_r     <= 1'b1;
        rd_data_r <= {DATA_WIDTH{1'b0}};
      end
    end
  end

  // Output decode from state and captured registers.
  always_comb begin
    s_cpuif_req       = issue_s;
    s_cpuif_req_is_wr = is_wr_r;
    s_cpuif_addr      = addr_r;
    s_cpuif_wr_data   = wr_data_r;
    s_cpuif_wr_biten  = biten_r;
    m_ack_o           = 2'b00;
    m_err_o           = 1'b0;
    m_rd_data_o       = {DATA_WIDTH{1'b0}};
    if (state_r == RESP) begin
      m_ack_o     = grant_r ? 2'b10 : 2'b01;
      m_err_o     = err_r;
      m_rd_data_o = rd_data_r;
    end else begin
      m_ack_o     = 2'b00;
      m_err_o     = 1'b0;
      m_rd_data_o = {DATA_WIDTH{1'b0}};
    end
`ifdef I3C_CPUIF_ARB_TIMEOUT_EN
    timeout_o = (state_r == RESP) && tmo_r;
`else
    timeout_o = 1'b0;
`endif
  end

endmodule

// File: doc/i3c_cpuif_arb.md
I3C_CPUIF_ARB -- requirements
Module: i3c_cpuif_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, CSR byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, CSR data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, response-wait limit (range 2..65535).
REQ-004 SHALL have port hclk_i  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port hreset_n_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port m_req_i  in  2  per-requester request; index 0 = AHB bridge, 1 = internal master.
REQ-007 SHALL have port m_req_is_wr_i  in  2  per-requester write flag.
REQ-008 SHALL have port m_addr_i  in  2*ADDR_WIDTH  per-requester byte address, requester n at [n*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port m_wr_data_i  in  2*DATA_WIDTH  per-requester write data.
REQ-010 SHALL have port m_wr_biten_i  in  2*DATA_WIDTH  per-requester bit-write-enables.
REQ-011 SHALL have port m_ack_o  out  2  one-cycle completion pulse to owning requester.
REQ-012 SHALL have port m_err_o  out  1  error flag, valid with any m_ack_o bit.
REQ-013 SHALL have port m_rd_data_o  out  DATA_WIDTH  read data, valid with m_ack_o on reads, 0 otherwise.
REQ-014 SHALL have port s_cpuif_req  out  1  one-cycle request to CSR block.
REQ-015 SHALL have port s_cpuif_req_is_wr  out  1  write flag to CSR block.
REQ-016 SHALL have port s_cpuif_addr  out  ADDR_WIDTH  address to CSR block.
REQ-017 SHALL have port s_cpuif_wr_data  out  DATA_WIDTH  write data to CSR block.
REQ-018 SHALL have port s_cpuif_wr_biten  out  DATA_WIDTH  bit enables to CSR block.
REQ-019 SHALL have port s_cpuif_req_stall_wr  in  1  CSR block cannot accept a write.
REQ-020 SHALL have port s_cpuif_req_stall_rd  in  1  CSR block cannot accept a read.
REQ-021 SHALL have port s_cpuif_rd_ack  in  1  read complete.
REQ-022 SHALL have port s_cpuif_rd_err  in  1  read error, valid with rd_ack.
REQ-023 SHALL have port s_cpuif_rd_data  in  DATA_WIDTH  read data, valid with rd_ack.
REQ-024 SHALL have port s_cpuif_wr_ack  in  1  write complete.
REQ-025 SHALL have port s_cpuif_wr_err  in  1  write error, valid with wr_ack.
REQ-026 SHALL have port timeout_o  out  1  one-cycle pulse when a transfer is aborted by timeout.

Function
REQ-027 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, one transfer outstanding at a time.
REQ-028 IDLE: if any m_req_i bit set, SHALL grant one, latch its is_wr/addr/wr_data/wr_biten into registers, go ISSUE next cycle; else stay.
REQ-029 Arbitration SHALL be round-robin: pointer moves to the other requester after each grant; on simultaneous requests the pointed requester wins; a lone requester always wins.
REQ-030 ISSUE: s_cpuif_req SHALL be 1 only when the stall matching the latched direction is 0; while stalled, stay ISSUE with s_cpuif_req=0.
REQ-031 s_cpuif_addr/wr_data/wr_biten/req_is_wr SHALL be driven from latched registers, stable from ISSUE through RESP.
REQ-032 An ack of the latched direction in the same cycle as s_cpuif_req SHALL go directly to RESP; otherwise go WAIT; in WAIT, the matching ack goes RESP.
REQ-033 Acks of the non-latched direction, and any ack in IDLE/ISSUE-while-stalled/RESP, SHALL be ignored.
REQ-034 RESP: m_ack_o[grant]=1 for exactly one cycle with registered err and rd_data (rd_data=0 for writes), then IDLE.
REQ-035 Best-case latency: request seen in IDLE cycle T, s_cpuif_req at T+1, m_ack_o at T+2 for same-cycle CSR ack.
REQ-036 Requesters SHALL hold m_req_i and payload until m_ack_o and drop or renew m_req_i in the following cycle; payload changes while granted SHALL NOT affect the transfer.

Reset
REQ-037 Asserting hreset_n_i at any time SHALL immediately force IDLE, pointer to requester 0, all outputs and latched registers 0, timeout counter 0; an in-flight transfer is dropped without m_ack_o.

Configuration
REQ-038 With I3C_CPUIF_ARB_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry, increment each WAIT cycle; at count TIMEOUT_CYCLES-1 without ack, go RESP with m_err_o=1, m_rd_data_o=0, timeout_o=1 in the RESP cycle.
REQ-039 Without I3C_CPUIF_ARB_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL last until ack, and timeout_o SHALL be tied 0.

Verification
REQ-040 Req0 read addr 0x010, CSR acks same cycle with rd_data 0xA5A5_0001 -> s_cpuif_req at T+1, m_ack_o=2'b01, m_rd_data_o=0xA5A5_0001, m_err_o=0 at T+2.
REQ-041 Both requesters write continuously after reset -> grants alternate 0,1,0,1; each m_ack_o pulse one cycle.
REQ-042 Req1 write with stall_wr high 5 cycles -> s_cpuif_req held 0 for 5 cycles, issued in cycle 6, then acked normally; concurrent stall_rd has no effect.
REQ-043 Read acked with rd_err=1 after 3 WAIT cycles -> m_err_o=1 with m_ack_o; a stray wr_ack during WAIT is ignored.
REQ-044 With I3C_CPUIF_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> m_err_o=1, timeout_o=1, m_rd_data_o=0 after 16 WAIT cycles; late ack in IDLE ignored.
REQ-045 hreset_n_i asserted during WAIT -> all outputs 0 immediately, no m_ack_o; next request after release granted to requester 0 on tie.
